rr_grant_ctrl: RTL and testbench

- Round-robin arbiter and controller that shares one resource among N requesters. The resource is, for example, a single D-flip-flop register slice with its gate logic.
- Each requester holds its request for as long as it owns the resource.
- The controller issues a registered one-hot grant, inserts one dead cycle between owners, and rotates priority so no requester starves.
- It sits between the requesting blocks and the shared register's enable/select mux.

---
 rtl/rr_grant_ctrl.sv | 126 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registered one-hot grant, one dead cycle between owners.
// Define RR_TIMEOUT_EN to revoke a grant held for MAX_HOLD cycles (pulses timeout).
module rr_grant_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] next_ptr;
  logic           owner_req;
  int unsigned    j;

  if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_grant_ctrl: N and MAX_HOLD must both be >= 2");
  end

  // First requester at or after ptr_q, wrapping modulo N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_q) + k) % N;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDW'(j);
      end
    end
  end

  assign next_ptr  = (32'(gnt_id) == N - 1) ? '0 : gnt_id + IDW'(1);
  assign owner_req = req[gnt_id];

`ifdef RR_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD);
  logic [CW-1:0] hold_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant   <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        StIdle, StGap: begin
          if (pick_vld) begin
            grant   <= N'(1) << pick_idx;
            gnt_id  <= pick_idx;
            busy    <= 1'b1;
            hold_q  <= '0;
            state_q <= StGrant;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (!owner_req || hold_q == CW'(MAX_HOLD - 1)) begin
            grant   <= '0;
            busy    <= 1'b0;
            ptr_q   <= next_ptr;
            timeout <= owner_req;
            state_q <= StGap;
          end else begin
            hold_q <= hold_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant   <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StGap: begin
          if (pick_vld) begin
            grant   <= N'(1) << pick_idx;
            gnt_id  <= pick_idx;
            busy    <= 1'b1;
            state_q <= StGrant;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (!owner_req) begin
            grant   <= '0;
            busy    <= 1'b0;
            ptr_q   <= next_ptr;
            state_q <= StGap;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: expectations queued at drive time, popped after each edge.
module tb_rr_grant_ctrl;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input string what, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s: got %b want %b", tag, what, got, want);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [1:0] id, input logic to);
    sb.push_back('{grant: g, id: id, to: to});
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "grant", grant, e.grant);
      chk(tag, "busy", {3'b0, busy}, {3'b0, |e.grant});
      chk(tag, "timeout", {3'b0, timeout}, {3'b0, e.to});
      if (e.grant != 4'b0) chk(tag, "gnt_id", {2'b0, gnt_id}, {2'b0, e.id});
    end
  endtask

  // Drive req between edges, expect the registered result just after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                      input logic to, input string tag);
    @(negedge clk);
    req = r;
    push_exp(g, id, to);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic clr_pulse(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1;
    push_exp(4'b0, 2'd0, 1'b0);
    compare(tag);
    chk(tag, "gnt_id", {2'b0, gnt_id}, 4'd0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #20000;
    $fatal(1, "FAIL watchdog: got no finish want finish within time limit");
  end

  initial begin
    logic [3:0] g;
    clr = 1'b1;
    req = 4'b1111;
    #3;
    push_exp(4'b0, 2'd0, 1'b0);
    compare("reset_async");
    chk("reset_async", "gnt_id", {2'b0, gnt_id}, 4'd0);
    @(posedge clk);
    #1;
    push_exp(4'b0, 2'd0, 1'b0);
    compare("reset_held");
    @(negedge clk);
    clr = 1'b0;
    req = 4'b0;

    repeat (3) step(4'b0000, 4'b0000, 2'd0, 1'b0, "idle");
    step(4'b0100, 4'b0100, 2'd2, 1'b0, "first_grant");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "first_release");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "first_idle");
    clr_pulse("clr_pulse_a");

    // Everyone requests; each owner holds 3 cycles then drops for one.
    for (int o = 0; o < 5; o++) begin
      g = 4'b0001 << (o % 4);
      repeat (3) step(4'b1111, g, 2'(o % 4), 1'b0, "rr_own");
      step(~g, 4'b0000, 2'd0, 1'b0, "rr_gap");
    end
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "rr_idle");

    step(4'b1001, 4'b1000, 2'd3, 1'b0, "wrap_own3");
    step(4'b1001, 4'b1000, 2'd3, 1'b0, "wrap_hold3");
    step(4'b0001, 4'b0000, 2'd0, 1'b0, "wrap_rel3");
    step(4'b1001, 4'b0001, 2'd0, 1'b0, "wrap_next0");
    step(4'b1000, 4'b0000, 2'd0, 1'b0, "fair_rel0");
    step(4'b1001, 4'b1000, 2'd3, 1'b0, "fair_next3");
    step(4'b0001, 4'b0000, 2'd0, 1'b0, "fair_rel3");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "fair_idle");

    step(4'b0010, 4'b0010, 2'd1, 1'b0, "short_grant");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "short_rel");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "short_idle");

    step(4'b0010, 4'b0010, 2'd1, 1'b0, "mid_grant");
    step(4'b0010, 4'b0010, 2'd1, 1'b0, "mid_hold");
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    push_exp(4'b0, 2'd0, 1'b0);
    compare("mid_clr");
    chk("mid_clr", "gnt_id", {2'b0, gnt_id}, 4'd0);
    req = 4'b0011;
    @(negedge clk);
    clr = 1'b0;
    step(4'b0011, 4'b0001, 2'd0, 1'b0, "post_clr");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "post_rel");
    clr_pulse("clr_pulse_b");

`ifdef RR_TIMEOUT_EN
    step(4'b0110, 4'b0010, 2'd1, 1'b0, "to_grant");
    repeat (MAX_HOLD - 1) step(4'b0110, 4'b0010, 2'd1, 1'b0, "to_hold");
    step(4'b0110, 4'b0000, 2'd0, 1'b1, "to_revoke");
    step(4'b0110, 4'b0100, 2'd2, 1'b0, "to_next");
`else
    step(4'b0110, 4'b0010, 2'd1, 1'b0, "hold_grant");
    repeat (55) step(4'b0110, 4'b0010, 2'd1, 1'b0, "hold_long");
`endif
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "final_rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
